// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared widths and owner-state encodings for the program
// memory arbiter, PC and IR blocks.
`default_nettype none

package imem_arbiter_pkg;

    localparam int C_AW = 8;
    localparam int C_DW = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOST  = 2'd2
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/imem_burst_guard.sv
// imem_burst_guard: counts consecutive host grants while a fetch waits and
// forces a fetch grant once MAX_HOST_BURST is reached.
`default_nettype none

module imem_burst_guard #(
    parameter int MAX_HOST_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_fetch_req,
    input  logic i_fetch_gnt,
    input  logic i_host_gnt,
    output logic o_force_fetch
);

    localparam logic [3:0] C_MAX = 4'(MAX_HOST_BURST);

    logic [3:0] r_bcnt;
    logic [3:0] w_bcnt_next;

    always_comb begin
        w_bcnt_next = r_bcnt;
        if (!i_fetch_req || i_fetch_gnt) begin
            w_bcnt_next = 4'd0;
        end else if (i_host_gnt && (r_bcnt != C_MAX)) begin
            w_bcnt_next = r_bcnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= 4'd0;
        end else begin
            r_bcnt <= w_bcnt_next;
        end
    end

    assign o_force_fetch = i_fetch_req && (r_bcnt == C_MAX);

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port program RAM between instruction fetch
// and a host loader port; host has priority, bounded by the burst guard.
`default_nettype none

module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int AW             = C_AW,
    parameter int DW             = C_DW,
    parameter int MAX_HOST_BURST = 4
) (
    input  logic          CLK,
    input  logic          CLB,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    output logic [DW-1:0] fetch_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_stall
);

    owner_e r_state;
    owner_e w_state_next;
    logic   w_force_fetch;
    logic   w_host_gnt;
    logic   w_fetch_gnt;

    imem_burst_guard #(
        .MAX_HOST_BURST (MAX_HOST_BURST)
    ) u_burst_guard (
        .clk           (CLK),
        .rst_n         (CLB),
        .i_fetch_req   (fetch_req),
        .i_fetch_gnt   (w_fetch_gnt),
        .i_host_gnt    (w_host_gnt),
        .o_force_fetch (w_force_fetch)
    );

    // Grants are masked while CLB is low so every output reads 0 in reset.
    assign w_host_gnt  = CLB && host_req && !w_force_fetch;
    assign w_fetch_gnt = CLB && fetch_req && !w_host_gnt;

    assign host_gnt   = w_host_gnt;
    assign fetch_gnt  = w_fetch_gnt;
    assign core_stall = CLB && fetch_req && !w_fetch_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_host_gnt) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (w_fetch_gnt) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr;
        end
    end

    always_comb begin
        w_state_next = ST_IDLE;
        if (w_fetch_gnt) begin
            w_state_next = ST_FETCH;
        end else if (w_host_gnt && !host_we) begin
            w_state_next = ST_HOST;
        end
    end

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign fetch_rvalid = (r_state == ST_FETCH);
    assign host_rvalid  = (r_state == ST_HOST);
    assign fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
    assign host_rdata   = host_rvalid  ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port program memory between two requesters: the core's instruction fetch (read-only) and a host loader/debug port (read/write).
- Sits between the controller/PC/IR path and the program RAM.
- Host has priority, bounded by a starvation guard so fetch always progresses.
- Fetch stalls are reported to the controller through core_stall.

Parameters:
- AW, 8, program memory address width (matches the 8-bit PC).
- DW, 12, instruction word width (4-bit opcode + 8-bit operand).
- MAX_HOST_BURST, 4, maximum consecutive host grants while fetch is pending; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- CLB  in  1  reset, asynchronous, active-low.
- fetch_req  in  1  core requests an instruction read.
- fetch_addr  in  AW  fetch address (PC).
- fetch_gnt  out  1  fetch granted this cycle.
- fetch_rvalid  out  1  fetch_rdata valid (one cycle after fetch_gnt).
- fetch_rdata  out  DW  instruction word.
- host_req  in  1  host requests an access.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_gnt  out  1  host granted this cycle.
- host_rvalid  out  1  host_rdata valid (reads only, one cycle after grant).
- host_rdata  out  DW  host read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; synchronous RAM, one-cycle latency.
- core_stall  out  1  fetch_req high and fetch_gnt low.

Behaviour:
- Reset (CLB low, async): all outputs 0; burst counter bcnt = 0; owner state = ST_IDLE; any pending rvalid is dropped and not replayed after reset release.
- Grant logic is combinational from the inputs and registered bcnt. At most one grant per cycle.
  - host_req && !(fetch_req && bcnt == MAX_HOST_BURST) -> host_gnt.
  - Otherwise fetch_req -> fetch_gnt.
  - Neither request -> no grant, mem_en = 0.
- Memory drive:
  - host_gnt: mem_en = 1, mem_we = host_we, mem_addr = host_addr, mem_wdata = host_wdata.
  - fetch_gnt: mem_en = 1, mem_we = 0, mem_addr = fetch_addr.
  - Idle: mem_addr and mem_wdata = 0.
- bcnt (4 bits):
  - Increments on host_gnt while fetch_req is high.
  - Clears on fetch_gnt, or in any cycle where fetch_req is low.
  - Saturates at MAX_HOST_BURST.
- Owner FSM (registered, routes read data):
  - ST_IDLE: no read outstanding.
  - ST_FETCH: fetch read outstanding.
  - ST_HOST: host read outstanding.
  - Next state is ST_FETCH on fetch_gnt, ST_HOST on host_gnt && !host_we, otherwise ST_IDLE. Host writes go to ST_IDLE.
  - fetch_rvalid = (state == ST_FETCH); host_rvalid = (state == ST_HOST).
  - fetch_rdata and host_rdata both carry mem_rdata, qualified by their rvalid.
- Latency: grant in cycle N -> rvalid and data in cycle N+1. Back-to-back grants are allowed every cycle; throughput is 1 access/cycle.
- Ordering: a host write to address A in cycle N followed by a fetch of A in cycle N+1 or later returns the new data. There is no same-cycle write/read conflict, since only one grant is issued.
- Requesters hold req/addr/data stable until their grant; the arbiter has no internal request buffering.
- core_stall is combinational: fetch_req && !fetch_gnt.
- Sustained host_req with fetch_req high: the pattern is MAX_HOST_BURST host grants, then 1 fetch grant, repeating.

Decomposition:
- Shared package holds:
  - Owner state encodings ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_HOST = 2'd2.
  - Default widths AW/DW, shared with the PC and IR blocks.
- One natural sub-module, imem_burst_guard: holds bcnt and its saturate/clear logic, and outputs force_fetch = fetch_req && bcnt == MAX_HOST_BURST. Grant mux and owner FSM stay in the top.

Test Plan:
- Reset: assert CLB = 0 mid-read (state ST_FETCH) -> fetch_rvalid = 0 immediately; after release with no requests, all outputs remain 0.
- Fetch only: fetch_req = 1, addr 0x00..0x03, memory preloaded with 0x1A5, 0x2FF, 0xD07, 0xF00 -> fetch_gnt every cycle; rvalid + rdata 0x1A5, 0x2FF, 0xD07, 0xF00 on cycles 1..4; core_stall = 0.
- Host write then fetch: host writes 0xB3C to 0x10 in cycle 0; fetch 0x10 in cycle 1 -> fetch_rdata = 0xB3C in cycle 2; host_rvalid never asserts.
- Starvation guard: host_req and fetch_req held high for 15 cycles, MAX_HOST_BURST = 4 -> grant pattern H,H,H,H,F repeated 3 times; core_stall high exactly on host-grant cycles.
- Read routing: alternating host read of 0x20 (0x3AA) and fetch of 0x21 (0x455) -> host_rvalid carries 0x3AA and fetch_rvalid carries 0x455 on the correct following cycles, never both high together.
- Burst clear: 3 host grants with fetch pending, then fetch_req drops for 1 cycle, then rises -> bcnt restarts at 0, so 4 further host grants precede the next forced fetch.
